// File: rtl/dom_indep_mul_pipe.sv
// -----------------------------------------------------------------------------
// dom_indep_mul_pipe
//
// Purpose:
//   Order-d masked AND gadget in domain-oriented-masking (DOM) style with
//   independent inputs. It multiplies WIDTH parallel bit lanes, and each
//   operand is split into SHARES = d+1 Boolean shares. Every cross-domain
//   product is remasked with one fresh random bit before it is registered.
//   Compression (the XOR of the terms into the output shares) is a pure XOR
//   tree that reads only stage-1 register outputs. This keeps domains
//   separated until the register boundary.
//
// Parameters:
//   SHARES  number of shares per operand (order d = SHARES-1), legal 2..8
//   WIDTH   number of independent bit lanes
//
// Ports:
//   clk        rising-edge clock for all registers
//   rst        asynchronous, active-high reset (released at a clk edge)
//   en         pipeline advance; when low, every register holds its value
//   in_valid   port_a/port_b/port_r carry an operation this cycle
//   port_a     operand a, share s / lane l at bit s*WIDTH+l
//   port_b     operand b, same layout
//   port_r     fresh randomness, pair k / lane l at bit k*WIDTH+l,
//              NR = SHARES*(SHARES-1)/2 pairs
//   out_valid  port_c holds a valid result
//   port_c     shared product c = a & b, same layout as port_a
//
// Configuration macro:
//   DOM_MUL_OUT_REG_EN  when defined, adds an output register behind the
//                       compression XOR. Latency becomes 2 cycles, and
//                       XOR-tree glitches never reach the outputs.
//                       When undefined, port_c is combinational from the
//                       stage-1 registers and latency is 1 cycle.
// -----------------------------------------------------------------------------
module dom_indep_mul_pipe #(
  parameter  int SHARES = 2,
  parameter  int WIDTH  = 1,
  localparam int NR     = SHARES * (SHARES - 1) / 2,
  localparam int SW     = SHARES * WIDTH
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic                in_valid,
  input  logic [SW-1:0]       port_a,
  input  logic [SW-1:0]       port_b,
  input  logic [NR*WIDTH-1:0] port_r,
  output logic                out_valid,
  output logic [SW-1:0]       port_c
);

  // One WIDTH-bit term per (i, j) share pair, including the inner terms i==j.
  localparam int NT = SHARES * SHARES;

  // Index of the random bit shared by domains i<j. Pairs are enumerated
  // row-major over the upper triangle.
  function automatic int pair_idx(input int i, input int j);
    return i * SHARES - i * (i + 1) / 2 + (j - i - 1);
  endfunction

  // Bit offset of term t_ij in the flat term vector.
  function automatic int term_base(input int i, input int j);
    return (i * SHARES + j) * WIDTH;
  endfunction

  logic [NT*WIDTH-1:0] t_d;
  logic [NT*WIDTH-1:0] t_q;
  logic                v1;
  logic [SW-1:0]       c_comb;

  // ---------------------------------------------------------------------------
  // Stage-1 term generation. Each term involves at most two domains and one
  // random bit. No XOR between different terms happens before the register.
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable written here gets a default first, so no path
    // can leave it unassigned and infer a latch.
    t_d = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        if (i == j) begin
          t_d[term_base(i, j) +: WIDTH] = port_a[i*WIDTH +: WIDTH] & port_b[i*WIDTH +: WIDTH];
        end else if (i < j) begin
          t_d[term_base(i, j) +: WIDTH] = (port_a[i*WIDTH +: WIDTH] & port_b[j*WIDTH +: WIDTH])
                                        ^ port_r[pair_idx(i, j)*WIDTH +: WIDTH];
        end else begin
          // t_ij with i>j reuses the random bit of pair (j, i). Together with
          // t_ji, this makes the remask cancel in the unmasked sum.
          t_d[term_base(i, j) +: WIDTH] = (port_a[i*WIDTH +: WIDTH] & port_b[j*WIDTH +: WIDTH])
                                        ^ port_r[pair_idx(j, i)*WIDTH +: WIDTH];
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage-1 registers. Data loads on every en cycle, whatever in_valid is.
  // in_valid only qualifies the result through v1.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: the term bank is a plain register file of flops, not a RAM, so
    // it is cleared on reset like any other state. Reset leaves no
    // previously masked data behind.
    if (rst) begin
      t_q <= '0;
      v1  <= 1'b0;
    end else if (en) begin
      // NOTE: sequential state uses non-blocking assignments, so every
      // register samples its pre-edge inputs regardless of statement order.
      t_q <= t_d;
      v1  <= in_valid;
    end
  end

  // ---------------------------------------------------------------------------
  // Compression: c_i = t_ii ^ XOR_{j != i} t_ij. The tree reads only
  // registered terms, so every random bit has already been folded in.
  // ---------------------------------------------------------------------------
  always_comb begin
    c_comb = '0;
    for (int i = 0; i < SHARES; i++) begin
      for (int j = 0; j < SHARES; j++) begin
        c_comb[i*WIDTH +: WIDTH] = c_comb[i*WIDTH +: WIDTH] ^ t_q[term_base(i, j) +: WIDTH];
      end
    end
  end

`ifdef DOM_MUL_OUT_REG_EN
  // ---------------------------------------------------------------------------
  // Optional output stage. It blocks XOR-tree glitches from the outputs and
  // adds one cycle of latency. It uses the same enable and reset as stage 1.
  // ---------------------------------------------------------------------------
  logic [SW-1:0] c_q;
  logic          v2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      c_q <= '0;
      v2  <= 1'b0;
    end else if (en) begin
      c_q <= c_comb;
      v2  <= v1;
    end
  end

  assign port_c    = c_q;
  assign out_valid = v2;
`else
  assign port_c    = c_comb;
  assign out_valid = v1;
`endif

endmodule

// File: tb/tb_dom_indep_mul_pipe.sv
// -----------------------------------------------------------------------------
// tb_dom_indep_mul_pipe
//
// Self-checking bench for dom_indep_mul_pipe. It uses two instances that
// share clk/rst/en:
//   dut2  SHARES=2, WIDTH=1  for the directed, randomness and reset cases
//   dut3  SHARES=3, WIDTH=4  for random back-to-back traffic and the stall
// Expected values come from a share-level reference model that enumerates
// domain pairs in order, and from unmasking (a & b).
// -----------------------------------------------------------------------------
module tb_dom_indep_mul_pipe;

`ifdef DOM_MUL_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  localparam int S2  = 2;
  localparam int W2  = 1;
  localparam int NR2 = 1;
  localparam int S3  = 3;
  localparam int W3  = 4;
  localparam int NR3 = 3;
  localparam int N3  = S3 * W3;
  localparam int R3  = NR3 * W3;
  localparam int NOPS = 100;

  logic clk = 1'b0;
  logic rst;
  logic en;

  logic                iv2;
  logic [S2*W2-1:0]    a2, b2;
  logic [NR2*W2-1:0]   r2;
  logic                ov2;
  logic [S2*W2-1:0]    c2;

  logic                iv3;
  logic [N3-1:0]       a3, b3;
  logic [R3-1:0]       r3;
  logic                ov3;
  logic [N3-1:0]       c3;

  int n_tests = 0;
  int n_fail  = 0;

  logic [N3-1:0] exp_c [NOPS];
  logic [W3-1:0] exp_u [NOPS];

  always #5 clk = ~clk;

  dom_indep_mul_pipe #(.SHARES(S2), .WIDTH(W2)) dut2 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv2),
    .port_a(a2), .port_b(b2), .port_r(r2),
    .out_valid(ov2), .port_c(c2)
  );

  dom_indep_mul_pipe #(.SHARES(S3), .WIDTH(W3)) dut3 (
    .clk(clk), .rst(rst), .en(en), .in_valid(iv3),
    .port_a(a3), .port_b(b3), .port_r(r3),
    .out_valid(ov3), .port_c(c3)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance one rising edge. Return at the following falling edge, where
  // outputs are sampled and new inputs are driven.
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  // Unmask a SHARES=3 vector by XOR-ing all shares.
  function automatic logic [W3-1:0] unmask3(input logic [N3-1:0] v);
    logic [W3-1:0] u;
    u = '0;
    for (int s = 0; s < S3; s++) u = u ^ v[s*W3 +: W3];
    return u;
  endfunction

  // Share-level DOM reference. Each share i accumulates a_i&b_i, plus
  // a_i&b_j^r for every other domain j. Random bits are handed out to the
  // pairs (i<j) in enumeration order.
  function automatic logic [N3-1:0] model3(input logic [N3-1:0] a, input logic [N3-1:0] b,
                                           input logic [R3-1:0] r);
    logic [N3-1:0] c;
    int k;
    c = '0;
    for (int i = 0; i < S3; i++)
      c[i*W3 +: W3] = a[i*W3 +: W3] & b[i*W3 +: W3];
    k = 0;
    for (int i = 0; i < S3; i++) begin
      for (int j = i + 1; j < S3; j++) begin
        c[i*W3 +: W3] = c[i*W3 +: W3] ^ (a[i*W3 +: W3] & b[j*W3 +: W3]) ^ r[k*W3 +: W3];
        c[j*W3 +: W3] = c[j*W3 +: W3] ^ (a[j*W3 +: W3] & b[i*W3 +: W3]) ^ r[k*W3 +: W3];
        k++;
      end
    end
    return c;
  endfunction

  task automatic rand_op3();
    a3 = N3'($urandom);
    b3 = N3'($urandom);
    r3 = R3'($urandom);
  endtask

  initial begin
    logic [N3-1:0] x_c;
    rst = 1'b1; en = 1'b0;
    iv2 = 1'b0; a2 = '0; b2 = '0; r2 = '0;
    iv3 = 1'b0; a3 = '0; b3 = '0; r3 = '0;

    // Reset state
    #1;
    check("rst_v2", ov2, 0);
    check("rst_c2", c2, 0);
    check("rst_v3", ov3, 0);
    check("rst_c3", c3, 0);
    @(negedge clk); @(negedge clk);
    rst = 1'b0; en = 1'b1;
    tick();

    // Directed: a=(1,0), b=(0,1), r=1 -> c=(0,1)
    a2 = 2'b01; b2 = 2'b10; r2 = 1'b1; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    check("dir_first_edge_v", ov2, LAT == 1);
    repeat (LAT - 1) tick();
    check("dir_v", ov2, 1);
    check("dir_c", c2, 2'b10);

    // Randomness sweep: a=b=(1,0). The share pair toggles with r, and the
    // unmasked value stays 1.
    for (int r = 0; r < 2; r++) begin
      a2 = 2'b01; b2 = 2'b01; r2 = r[0]; iv2 = 1'b1;
      tick();
      iv2 = 1'b0;
      repeat (LAT - 1) tick();
      check($sformatf("rnd_v_r%0d", r), ov2, 1);
      check($sformatf("rnd_c_r%0d", r), c2, (r == 0) ? 2'b01 : 2'b10);
      check($sformatf("rnd_u_r%0d", r), c2[0] ^ c2[1], 1);
    end

    // Back-to-back random traffic on SHARES=3, WIDTH=4
    for (int e = 0; e < NOPS + LAT - 1; e++) begin
      if (e < NOPS) begin
        rand_op3();
        iv3 = 1'b1;
        exp_c[e] = model3(a3, b3, r3);
        exp_u[e] = unmask3(a3) & unmask3(b3);
      end else begin
        iv3 = 1'b0;
      end
      tick();
      if (e - LAT + 1 >= 0) begin
        check($sformatf("b2b_v[%0d]", e - LAT + 1), ov3, 1);
        check($sformatf("b2b_c[%0d]", e - LAT + 1), c3, exp_c[e - LAT + 1]);
        check($sformatf("b2b_u[%0d]", e - LAT + 1), unmask3(c3), exp_u[e - LAT + 1]);
      end
    end
    iv3 = 1'b0;
    tick();

    // Stall: the result stays frozen while en=0, and inputs presented
    // during the stall are never captured.
    rand_op3();
    iv3 = 1'b1;
    x_c = model3(a3, b3, r3);
    tick();
    iv3 = 1'b0;
    rand_op3();
    repeat (LAT - 1) tick();
    check("stall_pre_v", ov3, 1);
    check("stall_pre_c", c3, x_c);
    en = 1'b0;
    for (int s = 0; s < 3; s++) begin
      rand_op3();
      iv3 = 1'b1;
      tick();
      check($sformatf("stall_v[%0d]", s), ov3, 1);
      check($sformatf("stall_c[%0d]", s), c3, x_c);
    end
    iv3 = 1'b0;
    en = 1'b1;
    for (int s = 0; s < LAT; s++) begin
      tick();
      check($sformatf("stall_post_v[%0d]", s), ov3, 0);
    end

    // Reset mid-operation on dut2
    a2 = 2'b01; b2 = 2'b10; r2 = 1'b1; iv2 = 1'b1;
    repeat (LAT) tick();
    check("rmid_pre_v", ov2, 1);
    check("rmid_pre_c", c2, 2'b10);
    iv2 = 1'b0;
    #2 rst = 1'b1;
    #1;
    check("rmid_async_v", ov2, 0);
    check("rmid_async_c", c2, 0);
    @(negedge clk);
    rst = 1'b0;
    for (int s = 0; s < LAT + 1; s++) begin
      tick();
      check($sformatf("rmid_idle_v[%0d]", s), ov2, 0);
    end
    a2 = 2'b01; b2 = 2'b01; r2 = 1'b0; iv2 = 1'b1;
    tick();
    iv2 = 1'b0;
    repeat (LAT - 1) tick();
    check("rmid_new_v", ov2, 1);
    check("rmid_new_c", c2, 2'b01);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
